// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-synchronous pong ball, paddle, score and serve/play/point/over sequencing
module pong_game_ctrl #(
  parameter int H_ACTIVE      = 800,
  parameter int V_ACTIVE      = 600,
  parameter int PADDLE_H      = 80,
  parameter int PADDLE_W      = 10,
  parameter int PADDLE_MARGIN = 16,
  parameter int PADDLE_STEP   = 4,
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int WIN_SCORE     = 9,
  parameter int SERVE_FRAMES  = 60
) (
  input  logic        CLK40MHZ,
  input  logic        rst_n,
  input  logic [11:0] Hindex,
  input  logic [11:0] Vindex,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [11:0] paddle_l_y,
  output logic [11:0] paddle_r_y,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic [1:0]  game_state,
  output logic        frame_tick
);
  localparam logic [11:0] HA   = 12'(H_ACTIVE);
  localparam logic [11:0] VA   = 12'(V_ACTIVE);
  localparam logic [11:0] PH   = 12'(PADDLE_H);
  localparam logic [11:0] STEP = 12'(PADDLE_STEP);
  localparam logic [11:0] BSZ  = 12'(BALL_SIZE);
  localparam logic [11:0] SPD  = 12'(BALL_SPEED);
  localparam logic [11:0] LX   = 12'(PADDLE_MARGIN + PADDLE_W);
  localparam logic [11:0] RX   = 12'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W);
  localparam logic [11:0] PMAX = 12'(V_ACTIVE - PADDLE_H);
  localparam logic [11:0] BX0  = 12'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] BY0  = 12'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [11:0] PY0  = 12'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
  localparam int          CW   = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [3:0]    btn_meta, btn_sync;
  logic          up_l, dn_l, up_r, dn_r;
  logic          dx_right, dy_down, scorer_left, armed;
  logic [CW-1:0] serve_cnt, cnt_nxt;
  logic [11:0]   bx_nxt, by_nxt, pl_nxt, pr_nxt;
  logic [3:0]    sl_nxt, sr_nxt, sl_inc, sr_inc;
  logic          dx_nxt, dy_nxt, scorer_nxt, armed_nxt;
  logic          ovl_l, ovl_r;

  assign {up_l, dn_l, up_r, dn_r} = btn_sync;
  assign game_state = state;
  assign sl_inc = score_l + 4'd1;
  assign sr_inc = score_r + 4'd1;
  // Overlap deliberately uses the paddle positions from before this tick's move
  assign ovl_l = (ball_y + BSZ > paddle_l_y) && (ball_y < paddle_l_y + PH);
  assign ovl_r = (ball_y + BSZ > paddle_r_y) && (ball_y < paddle_r_y + PH);

  function automatic logic [11:0] step_paddle(input logic [11:0] y, input logic up, input logic dn);
    logic [11:0] r;
    r = y;
    if (up && !dn)      r = (y <= STEP) ? 12'd0 : y - STEP;
    else if (dn && !up) r = (y + STEP >= PMAX) ? PMAX : y + STEP;
    return r;
  endfunction

  always_ff @(posedge CLK40MHZ or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta   <= '0;
      btn_sync   <= '0;
      frame_tick <= 1'b0;
    end else begin
      btn_meta   <= {btnU, btnD, btnL, btnR};
      btn_sync   <= btn_meta;
      frame_tick <= (Hindex == 12'd0) && (Vindex == VA);
    end
  end

  always_ff @(posedge CLK40MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SERVE;
      ball_x      <= BX0;
      ball_y      <= BY0;
      dx_right    <= 1'b1;
      dy_down     <= 1'b1;
      paddle_l_y  <= PY0;
      paddle_r_y  <= PY0;
      score_l     <= '0;
      score_r     <= '0;
      serve_cnt   <= '0;
      armed       <= 1'b0;
      scorer_left <= 1'b0;
    end else if (frame_tick) begin
      state       <= state_nxt;
      ball_x      <= bx_nxt;
      ball_y      <= by_nxt;
      dx_right    <= dx_nxt;
      dy_down     <= dy_nxt;
      paddle_l_y  <= pl_nxt;
      paddle_r_y  <= pr_nxt;
      score_l     <= sl_nxt;
      score_r     <= sr_nxt;
      serve_cnt   <= cnt_nxt;
      armed       <= armed_nxt;
      scorer_left <= scorer_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bx_nxt     = ball_x;
    by_nxt     = ball_y;
    dx_nxt     = dx_right;
    dy_nxt     = dy_down;
    pl_nxt     = paddle_l_y;
    pr_nxt     = paddle_r_y;
    sl_nxt     = score_l;
    sr_nxt     = score_r;
    cnt_nxt    = serve_cnt;
    armed_nxt  = armed;
    scorer_nxt = scorer_left;

    if (state == SERVE || state == PLAY) begin
      pl_nxt = step_paddle(paddle_l_y, up_l, dn_l);
      pr_nxt = step_paddle(paddle_r_y, up_r, dn_r);
    end

    case (state)
      SERVE: begin
        bx_nxt = BX0;
        by_nxt = BY0;
        if (serve_cnt == SERVE_LAST) begin
          state_nxt = PLAY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = serve_cnt + CW'(1);
        end
      end
      PLAY: begin
        if (!dy_down) begin
          if (ball_y <= SPD) begin
            by_nxt = 12'd0;
            dy_nxt = 1'b1;
          end else begin
            by_nxt = ball_y - SPD;
          end
        end else if (ball_y + BSZ + SPD >= VA) begin
          by_nxt = VA - BSZ;
          dy_nxt = 1'b0;
        end else begin
          by_nxt = ball_y + SPD;
        end

        // A ball already past a paddle face keeps going until it reaches the edge
        if (!dx_right) begin
          if (ball_x >= LX && ball_x <= LX + SPD && ovl_l) begin
            bx_nxt = LX;
            dx_nxt = 1'b1;
          end else if (ball_x <= SPD) begin
            bx_nxt     = 12'd0;
            scorer_nxt = 1'b0;
            state_nxt  = POINT;
          end else begin
            bx_nxt = ball_x - SPD;
          end
        end else begin
          if (ball_x + BSZ <= RX && ball_x + BSZ + SPD >= RX && ovl_r) begin
            bx_nxt = RX - BSZ;
            dx_nxt = 1'b0;
          end else if (ball_x + BSZ + SPD >= HA) begin
            bx_nxt     = HA - BSZ;
            scorer_nxt = 1'b1;
            state_nxt  = POINT;
          end else begin
            bx_nxt = ball_x + SPD;
          end
        end
      end
      POINT: begin
        if (scorer_left) sl_nxt = sl_inc;
        else             sr_nxt = sr_inc;
        if ((scorer_left ? sl_inc : sr_inc) == WIN) begin
          state_nxt = OVER;
        end else begin
          state_nxt = SERVE;
          bx_nxt    = BX0;
          by_nxt    = BY0;
          dx_nxt    = scorer_left;
          cnt_nxt   = '0;
        end
      end
      OVER: begin
        if (btn_sync == 4'b0000) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          armed_nxt = 1'b0;
          sl_nxt    = '0;
          sr_nxt    = '0;
          bx_nxt    = BX0;
          by_nxt    = BY0;
          pl_nxt    = PY0;
          pr_nxt    = PY0;
          cnt_nxt   = '0;
          state_nxt = SERVE;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - table-driven bench for pong_game_ctrl with hand-computed trajectories
module tb_pong_game_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] Hindex, Vindex;
  logic        btnU, btnD, btnL, btnR;
  logic [11:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
  logic [3:0]  score_l, score_r;
  logic [1:0]  game_state;
  logic        frame_tick;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .CLK40MHZ(clk), .rst_n(rst_n), .Hindex(Hindex), .Vindex(Vindex),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state), .frame_tick(frame_tick)
  );

  localparam int B_U = 8, B_D = 4, B_L = 2, B_R = 1;

  typedef struct {
    int          n;
    logic [3:0]  btn;
    logic [11:0] bx, by, pl, pr;
    logic [3:0]  sl, sr;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int n, int btn, int bx, int by, int pl, int pr, int sl, int sr, int st);
    vec_t v;
    v.n = n; v.btn = 4'(btn);
    v.bx = 12'(bx); v.by = 12'(by); v.pl = 12'(pl); v.pr = 12'(pr);
    v.sl = 4'(sl); v.sr = 4'(sr); v.st = 2'(st);
    return v;
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, " ball_x"},     ball_x,             v.bx);
    check({tag, " ball_y"},     ball_y,             v.by);
    check({tag, " paddle_l_y"}, paddle_l_y,         v.pl);
    check({tag, " paddle_r_y"}, paddle_r_y,         v.pr);
    check({tag, " score_l"},    12'(score_l),       12'(v.sl));
    check({tag, " score_r"},    12'(score_r),       12'(v.sr));
    check({tag, " game_state"}, 12'(game_state),    12'(v.st));
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btnU, btnD, btnL, btnR} = b;
  endtask

  // One frame: counter match, tick cycle, update cycle, then an idle cycle
  task automatic do_tick();
    @(negedge clk); Hindex = 12'd0; Vindex = 12'd600;
    @(negedge clk); Hindex = 12'd1; Vindex = 12'd0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_point(input int p, input int budget);
    int t;
    t = 0;
    while (game_state != 2'd2 && t < budget) begin
      do_tick();
      t++;
    end
    check($sformatf("p%0d reach_point", p), 12'(game_state), 12'd2);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Serve countdown, left paddle clamp, both-pressed, bottom bounce, right hit
    vq.push_back(mk( 59, 0,         396, 296, 260, 260, 0, 0, 0));
    vq.push_back(mk(  1, 0,         396, 296, 260, 260, 0, 0, 1));
    vq.push_back(mk(  1, 0,         398, 298, 260, 260, 0, 0, 1));
    vq.push_back(mk(  1, B_U,       400, 300, 256, 260, 0, 0, 1));
    vq.push_back(mk(  1, B_U,       402, 302, 252, 260, 0, 0, 1));
    vq.push_back(mk( 63, B_U,       528, 428,   0, 260, 0, 0, 1));
    vq.push_back(mk(  5, B_U,       538, 438,   0, 260, 0, 0, 1));
    vq.push_back(mk(  5, B_L | B_R, 548, 448,   0, 260, 0, 0, 1));
    vq.push_back(mk( 55, B_R,       658, 558,   0, 480, 0, 0, 1));
    vq.push_back(mk( 16, 0,         690, 590,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         692, 592,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         694, 590,   0, 480, 0, 0, 1));
    vq.push_back(mk( 35, 0,         764, 520,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         766, 518,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         764, 516,   0, 480, 0, 0, 1));
    // Top bounce, then a left miss with the paddle parked at 0
    vq.push_back(mk(256, 0,         252,   4,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         250,   2,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         248,   0,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,         246,   2,   0, 480, 0, 0, 1));
    vq.push_back(mk(108, 0,          30, 218,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,          28, 220,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,          26, 222,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,          24, 224,   0, 480, 0, 0, 1));
    vq.push_back(mk( 10, 0,           4, 244,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,           2, 246,   0, 480, 0, 0, 1));
    vq.push_back(mk(  1, 0,           0, 248,   0, 480, 0, 0, 2));
    vq.push_back(mk(  1, 0,         396, 296,   0, 480, 0, 1, 0));
    // Second serve toward the left, left paddle moved down to meet the ball
    vq.push_back(mk( 59, B_D,       396, 296, 236, 480, 0, 1, 0));
    vq.push_back(mk(  1, B_D,       396, 296, 240, 480, 0, 1, 1));
    vq.push_back(mk( 60, B_D,       276, 416, 480, 480, 0, 1, 1));
    vq.push_back(mk(124, 0,          28, 520, 480, 480, 0, 1, 1));
    vq.push_back(mk(  1, 0,          26, 518, 480, 480, 0, 1, 1));
    vq.push_back(mk(  1, 0,          28, 516, 480, 480, 0, 1, 1));
    vq.push_back(mk( 55, B_L,       138, 406, 480, 260, 0, 1, 1));

    rst_n = 1'b0;
    Hindex = 12'd100; Vindex = 12'd300;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    check_outs("reset", mk(0, 0, 396, 296, 260, 260, 0, 0, 0));
    check("reset frame_tick", 12'(frame_tick), 12'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vindex match with Hindex nonzero must not tick
    Hindex = 12'd5; Vindex = 12'd600;
    @(negedge clk);
    check("no_tick_hnz frame_tick", 12'(frame_tick), 12'd0);
    Hindex = 12'd1; Vindex = 12'd0;

    for (int i = 0; i < vq.size(); i++) begin
      set_btn(vq[i].btn);
      repeat (vq[i].n) do_tick();
      check_outs($sformatf("v%0d", i), vq[i]);
    end
    set_btn(4'b0000);

    // Left player scores to WIN_SCORE with the right paddle out of the ball's path
    for (int p = 1; p <= 9; p++) begin
      wait_point(p, 500);
      check($sformatf("p%0d point ball_x", p), ball_x, 12'd792);
      do_tick();
      check($sformatf("p%0d score_l", p), 12'(score_l), 12'(p));
      check($sformatf("p%0d score_r", p), 12'(score_r), 12'd1);
      check($sformatf("p%0d game_state", p), 12'(game_state), (p == 9) ? 12'd3 : 12'd0);
    end

    // Button held since entering OVER: never armed, stays frozen
    set_btn(4'(B_U));
    repeat (3) do_tick();
    check_outs("over_held", mk(0, 0, 792, ball_y, 480, 260, 9, 1, 3));
    set_btn(4'b0000);
    do_tick();
    check("over_armed game_state", 12'(game_state), 12'd3);
    set_btn(4'(B_D));
    do_tick();
    check_outs("restart", mk(0, 0, 396, 296, 260, 260, 0, 0, 0));

    // Mid-frame asynchronous reset
    set_btn(4'(B_U));
    repeat (3) do_tick();
    check("pre_reset paddle_l_y", paddle_l_y, 12'd248);
    Hindex = 12'd400; Vindex = 12'd300;
    #2 rst_n = 1'b0;
    #1;
    check_outs("midreset", mk(0, 0, 396, 296, 260, 260, 0, 0, 0));
    check("midreset frame_tick", 12'(frame_tick), 12'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Tick timing: match -> frame_tick on +1 with outputs unchanged -> update on +2
    Hindex = 12'd0; Vindex = 12'd600;
    @(negedge clk);
    check("timing +1 frame_tick", 12'(frame_tick), 12'd1);
    check("timing +1 paddle_l_y", paddle_l_y, 12'd260);
    Hindex = 12'd1; Vindex = 12'd0;
    @(negedge clk);
    check("timing +2 frame_tick", 12'(frame_tick), 12'd0);
    check("timing +2 paddle_l_y", paddle_l_y, 12'd256);
    set_btn(4'b0000);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-synchronous game-state controller for the pong design. It runs in the `CLK40MHZ` pixel domain and watches the 800x600 timing counters. Once per frame, at the start of vertical blank, it advances the ball, the paddles, the scores and the serve/play/point/game-over sequencing. Its registered outputs (ball and paddle coordinates, scores, state) feed the pixel renderer and the score display, and stay constant for the whole active-video region.

## Interface
Parameters:
- `H_ACTIVE`, 800: visible pixels per line.
- `V_ACTIVE`, 600: visible lines per frame.
- `PADDLE_H`, 80: paddle height in pixels.
- `PADDLE_W`, 10: paddle width in pixels.
- `PADDLE_MARGIN`, 16: gap between the screen edge and the paddle's outer side.
- `PADDLE_STEP`, 4: paddle move per frame, in pixels.
- `BALL_SIZE`, 8: ball side length in pixels (square ball).
- `BALL_SPEED`, 2: ball move per frame on each axis, in pixels.
- `WIN_SCORE`, 9: score that ends the game; must be ≤ 15.
- `SERVE_FRAMES`, 60: frames the ball is held at centre before play starts.

Ports:
- `CLK40MHZ` in 1: pixel clock, the only clock.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `Hindex` in 12: horizontal counter from the VGA timing generator.
- `Vindex` in 12: vertical counter from the VGA timing generator.
- `btnU`, `btnD` in 1 each: left paddle up/down; raw and asynchronous.
- `btnL`, `btnR` in 1 each: right paddle up/down; raw and asynchronous.
- `ball_x`, `ball_y` out 12 each: ball top-left corner.
- `paddle_l_y`, `paddle_r_y` out 12 each: top of each paddle.
- `score_l`, `score_r` out 4 each: player scores.
- `game_state` out 2: SERVE=0, PLAY=1, POINT=2, OVER=3.
- `frame_tick` out 1: one-cycle pulse; all updates happen on the cycle after it.

## Operation
- **Button synchronisers:** each button passes through a 2-flop synchroniser. The synchronised values are sampled only on `frame_tick`.
- **Frame tick:** `frame_tick` is registered. It is high for one cycle after the cycle where `Hindex`==0 and `Vindex`==`V_ACTIVE`. Exactly one pulse per frame.
- **Paddle movement:** applies in SERVE and PLAY only.
  - Up pressed alone: y = max(y−`PADDLE_STEP`, 0).
  - Down pressed alone: y = min(y+`PADDLE_STEP`, `V_ACTIVE`−`PADDLE_H`).
  - Both pressed, or neither: no move.
- **Fixed geometry:** left face LX = `PADDLE_MARGIN`+`PADDLE_W` = 26. Right face RX = `H_ACTIVE`−`PADDLE_MARGIN`−`PADDLE_W` = 774.
- **Overlap (per side):** ball_y+`BALL_SIZE` > paddle_y and ball_y < paddle_y+`PADDLE_H`. Evaluated using the paddle position before this tick's paddle update.
- **SERVE:**
  - Ball is held at (396, 296).
  - A serve counter increments once per tick.
  - When the counter reaches `SERVE_FRAMES`−1: go to PLAY and clear the counter.
- **PLAY:** on each tick, both ball axes are updated independently.
  - **Vertical, moving up:** if y ≤ `BALL_SPEED`, set y = 0 and flip dy to down; otherwise y −= `BALL_SPEED`.
  - **Vertical, moving down:** if y+`BALL_SIZE`+`BALL_SPEED` ≥ `V_ACTIVE`, set y = 592 and flip dy to up; otherwise y += `BALL_SPEED`.
  - **Horizontal, moving left (checks in priority order):**
    1. x ≥ LX, x ≤ LX+`BALL_SPEED`, and left overlap: set x = LX and flip dx to right.
    2. Else if x ≤ `BALL_SPEED`: set x = 0, record scorer = right, go to POINT.
    3. Else: x −= `BALL_SPEED`.
  - **Horizontal, moving right:** mirror of the left case.
    1. x+`BALL_SIZE` ≤ RX, x+`BALL_SIZE`+`BALL_SPEED` ≥ RX, and right overlap: set x = 766 and flip dx.
    2. Else if x+`BALL_SIZE`+`BALL_SPEED` ≥ `H_ACTIVE`: set x = 792, scorer = left, go to POINT.
    3. Else: x += `BALL_SPEED`.
  - A ball that has passed a paddle face continues moving until it reaches the edge condition.
- **POINT:** lasts for one tick.
  - The scorer's score is incremented.
  - If the new score equals `WIN_SCORE`, go to OVER.
  - Otherwise go to SERVE: ball re-centred, dx set toward the player who conceded, dy kept.
- **OVER:**
  - Ball, paddles and scores are frozen.
  - An `armed` flag is set on any tick where all four buttons are released.
  - On a tick where `armed` is set and any button is pressed: clear both scores and `armed`, re-centre the ball and paddles, and go to SERVE.
- **Reset values:**
  - Ball (396, 296), dx = right, dy = down.
  - Both paddles at 260.
  - Scores 0, `game_state` = SERVE.
  - Serve counter 0, `armed` = 0, `frame_tick` = 0.
  - Synchronisers at 0.
- **Reset mid-frame:** immediately restores all reset values. The next tick occurs at the next `Vindex`==`V_ACTIVE`, `Hindex`==0.

## Timing
- Button-to-sampled latency: 2 cycles through the synchroniser. The value is then held until the next tick.
- Counter match (`Hindex`==0, `Vindex`==`V_ACTIVE`) → `frame_tick` high on cycle +1 → all outputs updated on cycle +2.
- Outputs do not change outside the cycle after `frame_tick`. This guarantees stable values for all 600 active lines.
- State transitions take effect only on ticks. POINT therefore occupies exactly one frame.
- `game_state` and the position outputs change on the same clock edge.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame → ball (396,296), paddles 260/260, scores 0/0, `game_state`=0, `frame_tick`=0.
- **Serve countdown:** no buttons pressed → 59 ticks in SERVE with ball fixed. On the 60th tick → `game_state`=1 and ball unchanged. Next tick → ball (398,298).
- **Paddle clamp and both-pressed:** hold `btnU` for 70 ticks → `paddle_l_y` steps 260, 256, … and then holds at 0. Hold `btnL` and `btnR` together → `paddle_r_y` unchanged.
- **Wall bounce:** force ball_y=2 moving up in PLAY → next tick y=0 with dy=down; following tick y=2. Force y=590 moving down → y=592 with dy=up.
- **Paddle hit vs miss:**
  - Ball x=28 moving left, y=300, `paddle_l_y`=260 → x=26, dx=right.
  - Same with `paddle_l_y`=0 → ball continues left. At x ≤ 2 → POINT, then `score_r`+1, then SERVE with dx=left.
- **Game over:** drive `score_l` to 8, then a left point → `score_l`=9 and OVER.
  - Button held throughout → stays in OVER.
  - Release, then press → SERVE with scores 0/0 and paddles at 260.
